// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: display read, drawing write and RAM-port signals of the framebuffer arbiter
interface vga_fb_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_ack, rd_data, rd_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_ack, rd_data, rd_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one synchronous framebuffer RAM port between display reads and drawing writes
// Defining VGA_FB_ARB_WRCOUNT_EN adds a 16-bit wrapping count of granted writes (wr_count).
module vga_fb_arbiter #(
  parameter int AW           = 19,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 7,
  parameter int CW           = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic vblank,
  vga_fb_arbiter_if.slave bus,
  output logic starve_grant
`ifdef VGA_FB_ARB_WRCOUNT_EN
  ,
  output logic [15:0] wr_count
`endif
);
  logic [CW-1:0] wait_cnt;
  logic          starved;
  logic          grant_rd;
  logic          grant_wr;
  logic          en_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          rd_p1;
  logic          rd_p2;
  logic          valid_q;
  always_comb begin
    starved      = wait_cnt == CW'(STARVE_LIMIT);
    grant_wr     = reset & bus.wr_valid & (~bus.rd_req | vblank | starved);
    grant_rd     = reset & bus.rd_req & ~grant_wr;
    starve_grant = grant_wr & bus.rd_req & ~vblank & starved;
  end
  assign bus.rd_ack    = grant_rd;
  assign bus.wr_ready  = grant_wr;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rd_data   = rdata_q;
  assign bus.rd_valid  = valid_q;
  // rd_p1 tracks the RAM command cycle, rd_p2 the cycle mem_rdata is valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_p1    <= 1'b0;
      rd_p2    <= 1'b0;
      valid_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      en_q     <= grant_rd | grant_wr;
      we_q     <= grant_wr;
      if (grant_rd | grant_wr) addr_q <= grant_wr ? bus.wr_addr : bus.rd_addr;
      if (grant_wr) wdata_q <= bus.wr_data;
      rd_p1    <= grant_rd;
      rd_p2    <= rd_p1;
      valid_q  <= rd_p2;
      if (rd_p2) rdata_q <= bus.mem_rdata;
      wait_cnt <= grant_wr ? '0 : (bus.wr_valid & ~starved) ? wait_cnt + CW'(1) : wait_cnt;
    end
`ifdef VGA_FB_ARB_WRCOUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) wr_count <= '0;
    else if (grant_wr) wr_count <= wr_count + 16'd1;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized bench comparing the arbiter against a cycle-level reference model
module tb_vga_fb_arbiter;
  localparam int STARVE = 7;
  typedef struct {
    int         due;
    logic [7:0] d;
  } rd_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vblank = 1'b0;
  logic starve_grant;
`ifdef VGA_FB_ARB_WRCOUNT_EN
  logic [15:0] wr_count;
`endif
  vga_fb_arbiter_if #(.AW(19), .DW(8)) bus ();
  vga_fb_arbiter #(.AW(19), .DW(8), .STARVE_LIMIT(STARVE), .CW(4)) dut (
    .clk(clk),
    .reset(reset),
    .vblank(vblank),
    .bus(bus),
    .starve_grant(starve_grant)
`ifdef VGA_FB_ARB_WRCOUNT_EN
    ,
    .wr_count(wr_count)
`endif
  );
  always #5 clk = ~clk;
  logic [7:0] ram [0:(1<<19)-1];
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wcnt = 0;
  int wrc = 0;
  int nwr = 0;
  logic e_en = 1'b0;
  logic e_we = 1'b0;
  logic [18:0] e_addr = '0;
  logic [7:0] e_wd = '0;
  logic last_gr = 1'b0;
  logic last_gw = 1'b0;
  logic [7:0] ref_mem [int];
  rd_t q[$];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic post_checks();
    chk("mem_en", 32'(bus.mem_en), 32'(e_en));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("rd_data", 32'(bus.rd_data), 32'(q[0].d));
      void'(q.pop_front());
    end else chk("rd_valid", 32'(bus.rd_valid), 32'd0);
`ifdef VGA_FB_ARB_WRCOUNT_EN
    chk("wr_count", 32'(wr_count), 32'(wrc));
`endif
  endtask
  task automatic step(input logic r, input logic [18:0] ra, input logic w,
                      input logic [18:0] wa, input logic [7:0] wd, input logic vb);
    logic gw, gr;
    bus.rd_req = r; bus.rd_addr = ra;
    bus.wr_valid = w; bus.wr_addr = wa; bus.wr_data = wd;
    vblank = vb;
    #1;
    gw = w && (!r || vb || wcnt == STARVE);
    gr = r && !gw;
    chk("rd_ack", 32'(bus.rd_ack), 32'(gr));
    chk("wr_ready", 32'(bus.wr_ready), 32'(gw));
    chk("starve_grant", 32'(starve_grant), 32'(gw && r && !vb && wcnt == STARVE));
    last_gr = gr;
    last_gw = gw;
    e_en = gr || gw;
    e_we = gw;
    if (gr || gw) e_addr = gw ? wa : ra;
    if (gw) e_wd = wd;
    if (gr) q.push_back('{due: cyc + 3, d: ref_mem[int'(ra)]});
    if (gw) begin
      ref_mem[int'(wa)] = wd;
      wcnt = 0;
      wrc = (wrc + 1) & 'hffff;
      nwr++;
    end else if (w && wcnt < STARVE) wcnt++;
    @(posedge clk);
    #1;
    cyc++;
    post_checks();
  endtask
  task automatic model_reset();
    q.delete();
    wcnt = 0; wrc = 0;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
  endtask
  task automatic reset_checks();
    chk("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_starve", 32'(starve_grant), 32'd0);
    post_checks();
  endtask
  task automatic do_reset();
    bus.rd_req = 1'b1; bus.wr_valid = 1'b1; vblank = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    reset_checks();
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      reset_checks();
    end
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    logic pr, pw, vb;
    logic [18:0] pra, pwa;
    logic [7:0] pwd;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    #3;
    do_reset();
    step(1, 19'h00010, 1, 19'h00064, 8'h80, 0);
    step(0, '0, 1, 19'h00064, 8'h80, 0);
    step(0, '0, 1, 19'h12C00, 8'hFF, 0);
    for (int i = 0; i < 32; i++) step(0, '0, 1, 19'(i), 8'($urandom), 0);
    repeat (4) step(1, 19'h12C00, 0, '0, '0, 0);
    repeat (4) step(0, '0, 0, '0, '0, 0);
    nwr = 0;
    for (int i = 0; i < 24; i++) step(1, 19'($urandom_range(0, 31)), 1, 19'($urandom_range(0, 31)), 8'($urandom), 0);
    chk("starve_period_writes", 32'(nwr), 32'd3);
    repeat (5) step(1, 19'd3, 1, 19'($urandom_range(0, 31)), 8'($urandom), 1);
    step(1, 19'd3, 1, 19'd4, 8'h5A, 0);
    chk("vblank_fall_read", 32'(last_gr), 32'd1);
    pr = 0; pw = 0; pra = '0; pwa = '0; pwd = '0;
    last_gr = 0; last_gw = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pr || last_gr) begin pr = 1'($urandom_range(0, 1)); pra = 19'($urandom_range(0, 31)); end
      if (!pw || last_gw) begin pw = 1'($urandom_range(0, 1)); pwa = 19'($urandom_range(0, 31)); pwd = 8'($urandom); end
      vb = $urandom_range(0, 7) == 0;
      step(pr, pra, pw, pwa, pwd, vb);
    end
    repeat (4) step(0, '0, 0, '0, '0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 1, 19'(i + 40), 8'(i + 1), 0);
    step(1, 19'd41, 0, '0, '0, 0);
    reset = 1'b0;
    #1;
    model_reset();
    reset_checks();
    @(negedge clk);
    reset = 1'b1;
    repeat (6) step(0, '0, 0, '0, '0, 0);
    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
